// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array output drain.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } drain_state_t;

  localparam int unsigned SA_DRAIN_DEPTH = 2;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int unsigned sa_cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sa_row_fifo.sv
// Small synchronous FIFO holding whole array rows between shift-out and write.
module sa_row_fifo #(
  parameter int unsigned W     = 48,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [W-1:0]                 head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = ptr_next(wr_q);
    end
    if (pop) begin
      rd_d = ptr_next(rd_q);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign head  = mem_q[rd_q];

  // The producer's credit check must keep these unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (cnt_q == CW'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && (cnt_q == '0)));

endmodule

// File: rtl/sa_out_drain.sv
// Drains result rows out of the PE array into result memory with backpressure.
module sa_out_drain
  import sa_pkg::*;
#(
  parameter int unsigned X  = 3,
  parameter int unsigned Y  = 3,
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              cal_done,
  input  logic [AW-1:0]     base_addr,
  output logic              arr_shift_en,
  input  logic [Y*DW-1:0]   arr_out_data,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [Y*DW-1:0]   wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              drain_done,
  output logic              overrun
);

  localparam int unsigned CW  = sa_cnt_width(X);
  localparam int unsigned RW  = Y * DW;
  localparam int unsigned FCW = $clog2(SA_DRAIN_DEPTH + 1);
  localparam int unsigned OW  = FCW + 1;

  drain_state_t  state_q, state_d;
  logic [CW-1:0] issued_q, issued_d;
  logic [CW-1:0] written_q, written_d;
  logic [AW-1:0] base_q, base_d;
  logic          inflight_q, inflight_d;
  logic          overrun_q, overrun_d;

  logic [FCW-1:0] fifo_count;
  logic [RW-1:0]  fifo_head;
  logic           pop_c;
  logic [OW-1:0]  occupancy_c;

  sa_row_fifo #(
    .W     (RW),
    .DEPTH (SA_DRAIN_DEPTH)
  ) u_row_fifo (
    .clk   (clk),
    .rst   (sys_rst),
    .push  (inflight_q),
    .pop   (pop_c),
    .din   (arr_out_data),
    .count (fifo_count),
    .head  (fifo_head)
  );

  // Credit counts buffered plus in-flight rows; a same-cycle pop frees a slot.
  assign pop_c        = wr_en && wr_ready;
  assign occupancy_c  = OW'(fifo_count) + OW'(inflight_q);
  assign arr_shift_en = (state_q == SHIFT) && (issued_q < CW'(X)) &&
                        (occupancy_c < (OW'(SA_DRAIN_DEPTH) + OW'(pop_c)));

  assign wr_en      = (fifo_count != '0);
  assign wr_data    = fifo_head;
  assign wr_addr    = base_q + AW'(written_q);
  assign busy       = (state_q != IDLE);
  assign drain_done = (state_q == DONE);
  assign overrun    = overrun_q;

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    written_d  = written_q;
    base_d     = base_q;
    inflight_d = arr_shift_en;
    overrun_d  = overrun_q | (cal_done && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (cal_done) begin
          state_d   = SHIFT;
          base_d    = base_addr;
          issued_d  = '0;
          written_d = '0;
        end
      end
      SHIFT: begin
        if (arr_shift_en) begin
          issued_d = issued_q + CW'(1);
        end
        if (pop_c) begin
          written_d = written_q + CW'(1);
          if (written_q == CW'(X - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      written_q  <= '0;
      base_q     <= '0;
      inflight_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      written_q  <= written_d;
      base_q     <= base_d;
      inflight_q <= inflight_d;
      overrun_q  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_sa_out_drain.sv
// Directed bench for sa_out_drain: nominal, backpressure, wrap, overrun, mid-drain reset.
module tb_sa_out_drain;

  localparam int unsigned X  = 3;
  localparam int unsigned Y  = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;

  logic              clk;
  logic              sys_rst;
  logic              cal_done;
  logic [AW-1:0]     base_addr;
  logic              arr_shift_en;
  logic [Y*DW-1:0]   arr_out_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [Y*DW-1:0]   wr_data;
  logic              wr_ready;
  logic              busy;
  logic              drain_done;
  logic              overrun;

  logic [7:0]        tag;
  int                row_idx;
  int                n_vec;
  int                n_bad;

  sa_out_drain #(.X(X), .Y(Y), .DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .cal_done     (cal_done),
    .base_addr    (base_addr),
    .arr_shift_en (arr_shift_en),
    .arr_out_data (arr_out_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .busy         (busy),
    .drain_done   (drain_done),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row r, column c holds {tag, 3r+c+1}; column 0 in the LSBs.
  function automatic logic [Y*DW-1:0] row_word(input logic [7:0] t, input int r);
    logic [Y*DW-1:0] v;
    v = '0;
    for (int c = 0; c < int'(Y); c++) v[c*DW +: DW] = {t, 8'(3 * r + c + 1)};
    return v;
  endfunction

  // Array model: row data appears one cycle after a shift, junk otherwise.
  always @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      row_idx      <= 0;
      arr_out_data <= '0;
    end else if (arr_shift_en) begin
      arr_out_data <= row_word(tag, row_idx % int'(X));
      row_idx      <= row_idx + 1;
    end else begin
      arr_out_data <= {Y{16'hBAD0}};
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cal_done in cycle 0, extra cal_done pulses in cycles cal2/cal3, wr_ready low in slo..shi.
  task automatic run_drain(input string name, input logic [7:0] base, input logic [7:0] t,
                           input int slo, input int shi, input int cal2, input int cal3,
                           input logic [15:0] exp_shift, input logic [15:0] exp_wren,
                           input logic [15:0] exp_busy, input logic [15:0] exp_done,
                           input logic exp_ovr);
    logic [15:0]     sm, wm, bm, dm;
    logic [AW-1:0]   wa [8];
    logic [Y*DW-1:0] wd [8];
    logic [AW-1:0]   ea;
    int              nw;
    sm = '0; wm = '0; bm = '0; dm = '0; nw = 0;
    tag = t;
    tick();
    base_addr = base;
    cal_done  = 1'b1;
    for (int c = 1; c < 15; c++) begin
      tick();
      base_addr = ~base;
      cal_done  = (c == cal2) || (c == cal3);
      wr_ready  = !((c >= slo) && (c <= shi));
      #1;
      sm[c] = arr_shift_en;
      wm[c] = wr_en;
      bm[c] = busy;
      dm[c] = drain_done;
      if (wr_en && wr_ready && nw < 8) begin
        wa[nw] = wr_addr;
        wd[nw] = wr_data;
        nw++;
      end
    end
    cal_done = 1'b0;
    wr_ready = 1'b1;
    check({name, ".shift_cycles"}, 64'(sm), 64'(exp_shift));
    check({name, ".wr_en_cycles"}, 64'(wm), 64'(exp_wren));
    check({name, ".busy_cycles"},  64'(bm), 64'(exp_busy));
    check({name, ".done_cycle"},   64'(dm), 64'(exp_done));
    check({name, ".writes"},       64'(nw), 64'(X));
    for (int k = 0; k < int'(X); k++) begin
      ea = base + AW'(k);
      if (k < nw) begin
        check($sformatf("%s.addr%0d", name, k), 64'(wa[k]), 64'(ea));
        check($sformatf("%s.data%0d", name, k), 64'(wd[k]), 64'(row_word(t, k)));
      end
    end
    check({name, ".overrun"}, 64'(overrun), 64'(exp_ovr));
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    sys_rst   = 1'b1;
    cal_done  = 1'b0;
    base_addr = '0;
    wr_ready  = 1'b1;
    tag       = 8'h00;
    #2;
    check("rst.shift",   64'(arr_shift_en), 64'(0));
    check("rst.wr_en",   64'(wr_en),        64'(0));
    check("rst.busy",    64'(busy),         64'(0));
    check("rst.done",    64'(drain_done),   64'(0));
    check("rst.overrun", 64'(overrun),      64'(0));
    check("rst.wr_addr", 64'(wr_addr),      64'(0));
    check("rst.wr_data", 64'(wr_data),      64'(0));
    repeat (2) tick();
    sys_rst = 1'b0;

    run_drain("nominal", 8'h10, 8'h00, 1, 0, 0, 0,
              16'h000E, 16'h0038, 16'h007E, 16'h0040, 1'b0);
    run_drain("stall",   8'h10, 8'h01, 3, 6, 0, 0,
              16'h0086, 16'h03F8, 16'h07FE, 16'h0400, 1'b0);
    run_drain("wrap",    8'hFE, 8'h02, 1, 0, 0, 0,
              16'h000E, 16'h0038, 16'h007E, 16'h0040, 1'b0);
    run_drain("overrun", 8'h30, 8'h03, 1, 0, 2, 6,
              16'h000E, 16'h0038, 16'h007E, 16'h0040, 1'b1);
    repeat (3) tick();
    check("overrun.sticky", 64'(overrun), 64'(1));
    check("overrun.idle",   64'(busy),    64'(0));

    // Abort a drain in cycle 3 while row 0 is at the FIFO head.
    tag = 8'h05;
    tick();
    base_addr = 8'h20;
    cal_done  = 1'b1;
    tick();
    cal_done = 1'b0;
    tick();
    tick();
    check("abort.pre_wr_en", 64'(wr_en), 64'(1));
    sys_rst = 1'b1;
    #1;
    check("abort.shift",   64'(arr_shift_en), 64'(0));
    check("abort.wr_en",   64'(wr_en),        64'(0));
    check("abort.busy",    64'(busy),         64'(0));
    check("abort.done",    64'(drain_done),   64'(0));
    check("abort.overrun", 64'(overrun),      64'(0));
    check("abort.wr_addr", 64'(wr_addr),      64'(0));
    check("abort.wr_data", 64'(wr_data),      64'(0));
    repeat (2) tick();
    sys_rst = 1'b0;
    run_drain("fresh", 8'h40, 8'h06, 1, 0, 0, 0,
              16'h000E, 16'h0038, 16'h007E, 16'h0040, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sa_out_drain.md
# sa_out_drain

Result-drain controller on the output side of the systolic array. After the array controller pulses `cal_done`, this block shifts the X result rows out of the PE array, one row of Y words per shift, and writes each row to the result memory through a ready/valid write port with backpressure. It reports completion with `drain_done` and flags `cal_done` pulses that arrive while a drain is in progress.

## Interface
Parameters:
- `X`, 3: number of array rows, which is also the number of rows drained.
- `Y`, 3: number of array columns, which is also the number of words per row.
- `DW`, 16: width of one PE result word.
- `AW`, 8: result-memory address width.

Ports:
- `clk`, input, 1: the only clock. All state changes on the rising edge.
- `sys_rst`, input, 1: asynchronous, active-high reset.
- `cal_done`, input, 1: one-cycle pulse from the array controller meaning results are ready.
- `base_addr`, input, AW: address of row 0. Sampled when a drain starts.
- `arr_shift_en`, output, 1: tells the array to present its next row.
- `arr_out_data`, input, Y*DW: row data. Valid exactly 1 cycle after `arr_shift_en`. Column 0 is in the LSBs.
- `wr_en`, output, 1: write request to the result memory.
- `wr_addr`, output, AW: write address.
- `wr_data`, output, Y*DW: write data.
- `wr_ready`, input, 1: the memory accepts the write when `wr_en && wr_ready`.
- `busy`, output, 1: a drain is in progress.
- `drain_done`, output, 1: one-cycle completion pulse.
- `overrun`, output, 1: sticky error flag.

## Operation
- States and transitions:
  - IDLE → SHIFT when `cal_done`=1. On entry, latch `base_addr` and clear `issued_cnt` and `written_cnt`.
  - SHIFT → DONE when the write of row X−1 is accepted.
  - DONE → IDLE unconditionally after one cycle.
- `busy` = (state != IDLE). `drain_done` = (state == DONE).
- Row buffer: 2-entry FIFO of Y*DW-bit rows, plus an `inflight` bit meaning a shift was issued last cycle.
  - Push on every cycle where `inflight`=1, capturing `arr_out_data`.
  - Pop on `wr_en && wr_ready`.
- `arr_shift_en` = (state == SHIFT) && (`issued_cnt` < X) && (`fifo_count` + `inflight` − pop < 2).
  - The pop term is combinational from `wr_ready`, so throughput stays at 1 row/cycle.
  - Under the rule above the FIFO never overflows. Reaching an overflow condition is a design error and is covered by assertion.
- `wr_en` = FIFO non-empty. `wr_data` = FIFO head.
- `wr_addr` = latched base + `written_cnt`, truncated to AW bits; address wrap-around modulo 2^AW is legal.
- Rows are written strictly in shift order, starting at row 0.
- Counters are $clog2(X+1) bits wide. `issued_cnt` increments on `arr_shift_en`; `written_cnt` increments on an accepted write.
- `cal_done` while `busy`=1 is ignored for sequencing and sets `overrun`=1.
  - This includes `cal_done` during DONE.
  - `overrun` is cleared only by reset.
- `cal_done` in the same cycle that DONE returns to IDLE is also a flagged overrun, not a new start.
- Holding `wr_ready`=0 stalls shifting once 2 rows are buffered or in flight. No data is lost or duplicated.

## Timing
- Reset values: `arr_shift_en`, `wr_en`, `busy`, `drain_done` and `overrun` are all 0.
  - `wr_addr` = 0 and `wr_data` = 0 (the FIFO storage is cleared).
  - State = IDLE; counters, FIFO and `inflight` are cleared.
- Cycle numbering below takes `cal_done` sampled at cycle 0, with `wr_ready` held at 1:
  - `busy` is 1 in cycles 1..X+3.
  - `arr_shift_en` is 1 in cycles 1..X.
  - `wr_en` is 1 in cycles 3..X+2, with `wr_addr` = base+0 .. base+X−1.
  - `drain_done` is 1 in cycle X+3.
- Each cycle of `wr_ready`=0 while `wr_en`=1 extends `drain_done` by exactly one cycle.
- Reset asserted mid-drain aborts immediately. Everything returns to reset values and the pending rows are discarded.

## Structure
- Shared package `sa_pkg` holds:
  - the state enum `drain_state_t` (IDLE, SHIFT, DONE);
  - the counter width function/localparam;
  - a FIFO depth constant `SA_DRAIN_DEPTH`=2.
- Sub-module `sa_row_fifo`: a parameterised 2-entry synchronous FIFO with `push`, `pop`, `count`, `head`, and asynchronous active-high reset.
- The FSM, counters and credit logic live in `sa_out_drain`.

## Test plan
- X=3, Y=3, `base_addr`=0x10, `wr_ready`=1, array rows {1,2,3},{4,5,6},{7,8,9} → writes to 0x10, 0x11, 0x12 in cycles 3, 4, 5 with the matching rows; `drain_done` in cycle 6; `overrun`=0.
- Same setup, `wr_ready`=0 in cycles 3–6 → `arr_shift_en` stops after 2 rows are outstanding; all 3 rows are written once, in order; `drain_done` in cycle 10.
- `base_addr`=0xFE with AW=8 → `wr_addr` sequence 0xFE, 0xFF, 0x00.
- Second `cal_done` in cycle 2 and third in the DONE cycle → drain completes unchanged; `overrun`=1 and stays 1; no second drain starts.
- `sys_rst` asserted in cycle 3 (mid-drain), then a new `cal_done` → all outputs 0 during reset; the new drain writes rows 0..X−1 from the fresh base with no stale rows.
